// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Boot-time sequencer for the single-cycle RISC-V core. While the core is held
// in reset it receives a program as a byte stream over a valid/ready
// handshake. It packs the bytes little-endian into 32-bit words and writes
// them into instruction memory. When the stream ends it releases the core.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   start       one-cycle request to begin a (re)load
//   byte_valid  host byte present
//   byte_data   program byte
//   byte_last   final byte of the program, qualified by byte_valid
//   byte_ready  loader accepts a byte this cycle
//   imem_we     instruction memory write strobe (one cycle per word)
//   imem_addr   word-aligned byte address of the write
//   imem_wdata  assembled instruction word
//   core_run    1 = core out of reset
//   busy        load in progress
//   done        program loaded and core running
//   error       program longer than MAX_WORDS
//   word_count  words written in the current load
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_WC   = (ADDR_W + 1)'(MAX_WORDS);
    localparam logic [ADDR_W:0] WC_ONE   = (ADDR_W + 1)'(1);
    localparam int              ADDR_PAD = 32 - ADDR_W - 3;

    // Places a byte into lane 'lane' of a word, leaving the other lanes intact.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] res;
        res = word;
        case (lane)
            2'd0:    res[7:0]   = data;
            2'd1:    res[15:8]  = data;
            2'd2:    res[23:16] = data;
            2'd3:    res[31:24] = data;
            default: res        = word;
        endcase
        return res;
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        byte_idx_r;
    logic [31:0]       buf_r;
    logic [31:0]       merged_s;
    logic              handshake_s;
    logic              complete_s;
    logic              overflow_s;
    logic              write_s;
    logic              restart_s;

    logic              byte_ready_r;
    logic              imem_we_r;
    logic [31:0]       imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              core_run_r;
    logic              busy_r;
    logic              done_r;
    logic              error_r;
    logic [ADDR_W:0]   word_count_r;

    assign byte_ready = byte_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign core_run   = core_run_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign word_count = word_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake decode and next-state selection.
    always_comb begin
        state_next_s = state_r;
        handshake_s  = byte_valid & byte_ready_r & (state_r == ST_LOAD);
        // A word closes on its fourth byte or on the stream's final byte.
        complete_s   = handshake_s & ((byte_idx_r == 2'd3) | byte_last);
        // Completing a word with the memory already full is an overflow; no write.
        overflow_s   = complete_s & (word_count_r == MAX_WC);
        write_s      = complete_s & ~overflow_s;
        merged_s     = insert_byte(buf_r, byte_idx_r, byte_data);
        restart_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                    restart_s    = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (overflow_s) begin
                    state_next_s = ST_ERR;
                end else if (complete_s && byte_last) begin
                    state_next_s = ST_FLUSH;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_next_s = ST_RUN;
            end
            ST_RUN, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_LOAD;
                    restart_s    = 1'b1;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Byte lane index and partial-word assembly buffer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_idx_r <= 2'd0;
            buf_r      <= 32'h0000_0000;
        end else if (restart_s || complete_s) begin
            byte_idx_r <= 2'd0;
            buf_r      <= 32'h0000_0000;
        end else if (handshake_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            buf_r      <= merged_s;
        end else begin
            byte_idx_r <= byte_idx_r;
            buf_r      <= buf_r;
        end
    end

    // Registered outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_ready_r <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= 32'h0000_0000;
            imem_wdata_r <= 32'h0000_0000;
            core_run_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            word_count_r <= '0;
        end else begin
            byte_ready_r <= (state_next_s == ST_LOAD);
            busy_r       <= (state_next_s == ST_LOAD) || (state_next_s == ST_FLUSH);
            core_run_r   <= (state_next_s == ST_RUN);
            done_r       <= (state_next_s == ST_RUN);
            error_r      <= (state_next_s == ST_ERR);
            imem_we_r    <= write_s;
            if (write_s) begin
                // Address uses the count before this word is added.
                imem_addr_r  <= {{ADDR_PAD{1'b0}}, word_count_r, 2'b00};
                imem_wdata_r <= merged_s;
            end else begin
                imem_addr_r  <= imem_addr_r;
                imem_wdata_r <= imem_wdata_r;
            end
            if (restart_s) begin
                word_count_r <= '0;
            end else if (write_s) begin
                word_count_r <= word_count_r + WC_ONE;
            end else begin
                word_count_r <= word_count_r;
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader
// Self-checking bench for imem_boot_loader (MAX_WORDS=4 so overflow is reachable).
// A table of load vectors is streamed into the loader. The bench model
// computes the expected memory writes from each vector's bytes and queues
// them. A monitor pops and compares one entry for every imem_we it observes.
// Hand-written sequences cover reset in the middle of a load, and a reload
// after that reset.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_last;
    logic              byte_ready;
    logic              imem_we;
    logic [31:0]       imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_run;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [159:0] data;          // byte i at [8i+7:8i]
        logic [4:0]   nbytes;
        logic         use_last;
        logic         stall;         // insert a valid=0 gap before odd bytes
        logic [31:0]  exp_last_word;
        logic [8:0]   exp_wc;        // expected writes / final word_count
        logic         exp_err;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb[$];
    wr_t         mon_exp;
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic [31:0] last_wdata = 32'h0;
    vec_t        tbl[4];
    vec_t        v_rst;
    vec_t        v_reload;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            writes_seen++;
            last_wdata = imem_wdata;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_exp = sb.pop_front();
                check("wr_addr", imem_addr, mon_exp.addr);
                check("wr_data", imem_wdata, mon_exp.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 32'd0);
        check({tag, "_imem_we"},    imem_we,    32'd0);
        check({tag, "_imem_addr"},  imem_addr,  32'd0);
        check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check({tag, "_core_run"},   core_run,   32'd0);
        check({tag, "_busy"},       busy,       32'd0);
        check({tag, "_done"},       done,       32'd0);
        check({tag, "_error"},      error,      32'd0);
        check({tag, "_word_count"}, 32'(word_count), 32'd0);
    endtask

    // Model: little-endian packing, partial final word zero-filled, capped at MAX_WORDS.
    task automatic push_expected(input vec_t v);
        int          nw;
        int          n;
        wr_t         e;
        logic [31:0] w;
        n  = int'(v.nbytes);
        nw = v.use_last ? (n + 3) / 4 : n / 4;
        for (int wi = 0; wi < nw && wi < MAX_WORDS; wi++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * wi + j < n) w[8*j +: 8] = v.data[8*(4*wi+j) +: 8];
            end
            e.addr = 32'(4 * wi);
            e.data = w;
            sb.push_back(e);
        end
    endtask

    // Start pulse with a byte offered in the same cycle; that byte must be ignored.
    task automatic do_start();
        start      = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        @(posedge clk); #1;
        start      = 1'b0;
        byte_valid = 1'b0;
        check("start_byte_ready", byte_ready, 32'd1);
        check("start_busy",       busy,       32'd1);
        check("start_core_run",   core_run,   32'd0);
        check("start_done",       done,       32'd0);
        check("start_error",      error,      32'd0);
        check("start_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic l, input logic stall);
        logic acc;
        acc       = 1'b0;
        byte_data = b;
        byte_last = l;
        if (stall) begin
            byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        for (int c = 0; c < 20 && !acc; c++) begin
            acc = byte_ready;
            @(posedge clk); #1;
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: byte 0x%02h not accepted within 20 cycles", b);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int n;
        n = int'(v.nbytes);
        push_expected(v);
        writes_seen = 0;
        do_start();
        for (int i = 0; i < n; i++) begin
            send_byte(v.data[8*i +: 8], v.use_last && (i == n - 1), v.stall && (i % 2 == 1));
        end
        if (v.exp_err) begin
            check("ovf_error",      error,      32'd1);
            check("ovf_byte_ready", byte_ready, 32'd0);
            check("ovf_core_run",   core_run,   32'd0);
            check("ovf_busy",       busy,       32'd0);
            @(posedge clk); #1;
            check("ovf_error_hold", error,      32'd1);
            check("ovf_writes",     32'(writes_seen), 32'(v.exp_wc));
            check("ovf_last_word",  last_wdata, v.exp_last_word);
            check("ovf_sb_empty",   32'(sb.size()), 32'd0);
        end else if (v.use_last) begin
            check("flush_byte_ready", byte_ready, 32'd0);
            check("flush_busy",       busy,       32'd1);
            check("flush_core_run",   core_run,   32'd0);
            @(posedge clk); #1;
            check("run_core_run",   core_run, 32'd1);
            check("run_done",       done,     32'd1);
            check("run_busy",       busy,     32'd0);
            check("run_byte_ready", byte_ready, 32'd0);
            check("run_word_count", 32'(word_count), 32'(v.exp_wc));
            check("run_writes",     32'(writes_seen), 32'(v.exp_wc));
            check("run_last_word",  last_wdata, v.exp_last_word);
            check("run_sb_empty",   32'(sb.size()), 32'd0);
        end
    endtask

    initial begin
        logic [159:0] seq;
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_last  = 1'b0;

        seq = 160'h0;
        for (int i = 0; i < 20; i++) seq[8*i +: 8] = 8'(i + 1);

        tbl[0] = '{data: 160'h00A00113_00500093, nbytes: 5'd8, use_last: 1'b1, stall: 1'b0,
                   exp_last_word: 32'h00A00113, exp_wc: 9'd2, exp_err: 1'b0};
        tbl[1] = '{data: 160'h1615_14131211, nbytes: 5'd6, use_last: 1'b1, stall: 1'b0,
                   exp_last_word: 32'h00001615, exp_wc: 9'd2, exp_err: 1'b0};
        tbl[2] = '{data: 160'h00A00113_00500093, nbytes: 5'd8, use_last: 1'b1, stall: 1'b1,
                   exp_last_word: 32'h00A00113, exp_wc: 9'd2, exp_err: 1'b0};
        tbl[3] = '{data: seq, nbytes: 5'd20, use_last: 1'b0, stall: 1'b0,
                   exp_last_word: 32'h100F0E0D, exp_wc: 9'd4, exp_err: 1'b1};
        v_rst    = '{data: 160'h25_24232221, nbytes: 5'd5, use_last: 1'b0, stall: 1'b0,
                     exp_last_word: 32'h24232221, exp_wc: 9'd1, exp_err: 1'b0};
        v_reload = '{data: 160'hEFBEADDE, nbytes: 5'd4, use_last: 1'b1, stall: 1'b0,
                     exp_last_word: 32'hEFBEADDE, exp_wc: 9'd1, exp_err: 1'b0};

        // Reset held for two cycles, outputs checked on each.
        @(posedge clk); #1;
        check_all_zero("rst1");
        @(posedge clk); #1;
        check_all_zero("rst2");
        reset = 1'b1;
        byte_valid = 1'b1;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        check("idle_byte_ready", byte_ready, 32'd0);
        check("idle_writes", 32'(writes_seen), 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_vector(tbl[t]);
        end

        // Reset in the middle of a load, after one word has been written.
        run_vector(v_rst);
        @(posedge clk); #1;
        check("midload_writes", 32'(writes_seen), 32'd1);
        check("midload_busy", busy, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check_all_zero("midrst");
        reset = 1'b1;
        @(posedge clk); #1;
        check("postrst_byte_ready", byte_ready, 32'd0);

        // Fresh load after the abort starts again at address 0.
        run_vector(v_reload);

        repeat (3) @(posedge clk);
        #1;
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        check("final_core_run", core_run, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time sequencer for the single-cycle RISC-V core.
- Holds the core in reset while it receives a program as a byte stream over a valid/ready handshake.
- Packs the bytes little-endian into 32-bit words, writes them into instruction memory through a dedicated write port, then releases the core to run.
- Sits between the external host interface and the instruction memory, and drives the core's reset.

Parameters:
- ADDR_W, 8: word-address width of instruction memory.
- MAX_WORDS, 256: maximum program length in words; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle request to begin a (re)load.
- byte_valid  input  1  host byte present.
- byte_data  input  8  program byte.
- byte_last  input  1  final byte of program; qualified by byte_valid.
- byte_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe.
- imem_addr  output  32  byte address of write, always word-aligned.
- imem_wdata  output  32  assembled instruction word.
- core_run  output  1  1 = core out of reset; core reset is driven from its inverse.
- busy  output  1  loading in progress.
- done  output  1  program loaded, core running.
- error  output  1  overflow detected.
- word_count  output  ADDR_W+1  words written in the current load.

Behaviour:
- Reset (reset=0 at a clock edge):
  - State becomes IDLE.
  - All outputs are 0, including byte_ready, imem_we, imem_addr, imem_wdata, core_run and word_count.
  - The byte index and the assembly buffer clear.
  - Reset mid-load aborts immediately. Words already written remain in memory. The core stays held.
- States: IDLE, LOAD, FLUSH, RUN, ERR. All outputs are registered.
- IDLE:
  - byte_ready=0; byte_valid is ignored.
  - start=1 → LOAD. Clears word_count and the byte index.
- LOAD:
  - busy=1, byte_ready=1, core_run=0.
  - A handshake is byte_valid & byte_ready.
  - Byte k of a word (k = 0..3) goes to buffer bits [8k+7:8k].
  - start is ignored in this state.
- Word completion:
  - Trigger: handshake at edge N with k=3, or with byte_last=1.
  - At N+1: imem_we=1 for exactly one cycle.
  - imem_addr = word_count*4 using the pre-increment value.
  - imem_wdata = the buffer; unfilled upper bytes are 0.
  - word_count increments. The byte index wraps to 0 and the buffer clears.
- Back-to-back bytes: byte_ready stays high while a write issues. A new byte accepted in the same cycle starts the next word.
- byte_last:
  - The handshake at edge N completes the word (possibly partial) as above and moves the state to FLUSH at N+1.
  - byte_ready=0 from N+1.
  - At N+2 the state is RUN, with core_run=1, done=1 and busy=0.
- Overflow:
  - Trigger: a word completion is triggered while word_count==MAX_WORDS.
  - Next cycle the state is ERR and no write occurs.
  - ERR outputs: error=1, byte_ready=0, core_run=0, busy=0.
- RUN:
  - core_run=1 and done=1, held indefinitely.
  - start=1 → LOAD. core_run, done and word_count clear at the next edge.
- ERR: start=1 → LOAD; error clears.
- start together with byte_valid in IDLE, RUN or ERR: that byte is not accepted, because byte_ready=0 that cycle.
- Valid without ready: the host must hold byte_data and byte_last until the handshake. The loader never drops an accepted byte.

Test Plan:
1. Reset and start:
   - Stimulus: reset low 2 cycles, release, start pulse.
   - Required: all outputs 0 during reset; byte_ready=1 the cycle after start; core_run=0.
2. Two-word load:
   - Stimulus: stream 0x93,0x00,0x50,0x00,0x13,0x01,0xA0,0x00, last on the 8th byte.
   - Required:
     - First write: addr=0x0, wdata=0x00500093.
     - Second write: addr=0x4, wdata=0x00A00113.
     - core_run=1 and done=1 two cycles after the last byte; word_count=2.
3. Partial final word:
   - Stimulus: 6 bytes 0x11..0x16, last on 0x16.
   - Required: second write is addr=0x4, wdata=0x00001615; then RUN.
4. Handshake stall:
   - Stimulus: byte_valid toggled 1/0 with gaps, data held.
   - Required: bytes are accepted only when valid=1; wdata is identical to the gap-free run.
5. Overflow:
   - Stimulus: MAX_WORDS=4; stream 20 bytes without last.
   - Required:
     - Exactly 4 writes, at addr 0x0–0xC.
     - error=1 after the 20th byte is accepted; byte_ready=0; core_run=0.
     - A start pulse then returns the block to LOAD with error=0.
6. Reset mid-load and reload:
   - Stimulus: reset asserted after 5 bytes.
   - Required: IDLE next edge, all outputs 0.
   - Stimulus: from RUN, pulse start.
   - Required: core_run=0 next edge; a new load begins at addr 0x0.
